// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver feeding the scan-code decoder.
// Synchronises and deglitches ps2_clk/ps2_data, deserialises 11-bit frames,
// folds E0/F0 prefixes into key_ext/key_release, and strobes key_valid once per
// key event. frame_err strobes on a bad stop bit or a mid-frame timeout.
// Optional macro PS2_PARITY_CHECK_EN: when defined, odd parity is also enforced.
module ps2_scancode_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_valid,
   output logic       key_release,
   output logic       key_ext,
   output logic       frame_err
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t          state;
   logic [1:0]      clk_sync;
   logic [1:0]      data_sync;
   logic            clk_filt;
   logic [FW-1:0]   filt_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            e0_flag;
   logic            f0_flag;
   logic [TW-1:0]   to_cnt;
`ifdef PS2_PARITY_CHECK_EN
   logic            parity;
`endif

   logic clk_s;
   logic data_s;
   logic filt_hit;
   logic fall;
   logic frame_good;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // The filtered clock flips on the FILTER_LEN-th consecutive disagreeing cycle.
   assign filt_hit = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
   // A fall is that flip in the 1->0 direction; it is seen on the same cycle.
   assign fall     = filt_hit && clk_filt;

   // Stop bit is data_s on the STOP-state fall; parity is optional.
`ifdef PS2_PARITY_CHECK_EN
   assign frame_good = data_s && (^{shift, parity});
`else
   assign frame_good = data_s;
`endif

   // Two-flop synchronisers; preset to the idle-high bus level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Glitch filter: filtered clock follows only sustained level changes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s != clk_filt) begin
         if (filt_hit) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end else begin
         filt_cnt <= '0;
      end
   end

   // Frame FSM, prefix tracking, timeout and registered output strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         e0_flag     <= 1'b0;
         f0_flag     <= 1'b0;
         to_cnt      <= '0;
`ifdef PS2_PARITY_CHECK_EN
         parity      <= 1'b0;
`endif
         key_code    <= 8'h00;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         key_ext     <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            // A fall always restarts the timeout, even on the expiry cycle.
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!data_s) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift   <= {data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  parity <= data_s;
`endif
                  state  <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (frame_good) begin
                     if (shift == 8'hE0) begin
                        e0_flag <= 1'b1;
                     end else if (shift == 8'hF0) begin
                        f0_flag <= 1'b1;
                     end else begin
                        key_code    <= shift;
                        key_release <= f0_flag;
                        key_ext     <= e0_flag;
                        key_valid   <= 1'b1;
                        e0_flag     <= 1'b0;
                        f0_flag     <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     e0_flag   <= 1'b0;
                     f0_flag   <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            // Mid-frame with no clock activity: abort once the budget runs out.
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state     <= IDLE;
               to_cnt    <= '0;
               frame_err <= 1'b1;
               e0_flag   <= 1'b0;
               f0_flag   <= 1'b0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule
